ppu_cpu_port: RTL and testbench
===============================

# ppu_cpu_port

CPU-facing register file of the PPU. It decodes CPU accesses to $2000–$3FFF (8 registers, mirrored) and maintains the loopy-style VRAM address, fine scroll, write toggle, read buffer and vblank/NMI status. It arbitrates with the video fetch engine for the shared 14-bit VRAM bus, and stalls the CPU through `lock_cpu` while a $2007 transfer waits for a bus slot. Palette writes ($3F00–$3FFF) go straight to the renderer's palette port without using the VRAM bus.

## Interface

Parameters:
- `INC_DEFAULT`, 1 — VRAM increment after reset when ctrl[2]=0 (ctrl[2]=1 selects +32).

Ports:
- `clock`  in  1  — system clock; all state updates on the rising edge.
- `reset_n`  in  1  — reset, synchronous, active-low.
- `address`  in  16  — CPU address.
- `in`  in  8  — CPU write data.
- `rd`  in  1  — one-cycle CPU read strobe.
- `we`  in  1  — one-cycle CPU write strobe.
- `out`  out  8  — registered CPU read data.
- `lock_cpu`  out  1  — CPU stall; high while a $2007 transfer is pending.
- `vblank_set`  in  1  — one-cycle pulse from the renderer at the start of vblank.
- `vblank_clr`  in  1  — one-cycle pulse at pre-render; clears vblank.
- `nmi`  out  1  — level output = status[7] & ctrl[7].
- `vram_req`  out  1  — request for a VRAM bus slot.
- `vram_gnt`  in  1  — renderer grants the bus for this cycle.
- `vram_addr`  out  14  — VRAM address, valid while `vram_req` is high.
- `vram_in`  in  8  — VRAM read data, valid 1 cycle after the granted cycle.
- `vram_out`  out  8  — VRAM write data.
- `vram_we`  out  1  — VRAM write enable, high only in the granted cycle.
- `pal_we`  out  1  — palette write strobe, one cycle.
- `pal_idx`  out  5  — palette index, with $10/$14/$18/$1C folded to $00/$04/$08/$0C.
- `pal_data`  out  6  — palette entry, `in[5:0]`.
- `ctrl`  out  8  — $2000 value.
- `mask`  out  8  — $2001 value.
- `scroll_t`  out  15  — temp address t.
- `fine_x`  out  3  — fine X scroll.

## Operation

- **Decode.** A register is selected when `address[15:13]==3'b001`; the register number is `address[2:0]`. Accesses outside this range are ignored and `out` holds its value.
- **$2000 write.**
  - ctrl <= in.
  - t[11:10] <= in[1:0].
- **$2001 write.** mask <= in.
- **$2002 read.**
  - out <= {vblank, 7'b0}.
  - vblank <= 0.
  - w <= 0.
  - A read in the same cycle as `vblank_set` returns 0 and leaves vblank=1.
- **$2005 write, w=0.**
  - t[4:0] <= in[7:3].
  - fine_x <= in[2:0].
  - w <= 1.
- **$2005 write, w=1.**
  - t[14:12] <= in[2:0].
  - t[9:5] <= in[7:3].
  - w <= 0.
- **$2006 write, w=0.**
  - t[13:8] <= in[5:0].
  - t[14] <= 0.
  - w <= 1.
- **$2006 write, w=1.**
  - t[7:0] <= in.
  - v <= {t[14:8], in}.
  - w <= 0.
- **$2007 write, v[13:8]==6'h3F.**
  - pal_we=1 for one cycle.
  - pal_idx = v[4:0] folded.
  - v += inc.
  - No stall.
- **$2007 write, other v.** Enter WR_WAIT.
- **$2007 read.**
  - out <= rd_buf immediately.
  - Enter RD_WAIT to refill rd_buf from VRAM at v[13:0]; for palette-range v, the refill address is v & 14'h2FFF.
- **Registers 3 and 4 (OAM).** Writes ignored; reads return 0.
- **Increment.** inc = ctrl[2] ? 32 : 1. v is 15 bits and wraps modulo 2^15. vram_addr = v[13:0].
- **FSM states.**
  - IDLE: transition on a $2007 VRAM access.
  - WR_WAIT: vram_req=1, vram_out=latched data. On vram_gnt, vram_we=1 that cycle, v += inc, → IDLE.
  - RD_WAIT: vram_req=1. On vram_gnt → RD_LAT.
  - RD_LAT: rd_buf <= vram_in, v += inc, → IDLE.
- **lock_cpu.** High whenever the state is not IDLE.
- **CPU strobes while locked.** Any rd/we arriving while lock_cpu=1 is a CPU protocol violation. It is ignored; the bench checks that none occur.
- **vblank.**
  - Set by vblank_set.
  - Cleared by vblank_clr or a $2002 read.
  - If vblank_clr and vblank_set arrive together, set wins.
- **Reset (reset_n=0 at an edge).**
  - Forces IDLE and clears ctrl, mask, t, v, fine_x, w, vblank, rd_buf and out.
  - Forces out, nmi, lock_cpu, vram_req, vram_we, pal_we and vram_addr to 0.
  - Reset mid-transfer abandons the access with no write.

## Timing

- **Register writes.** Effective on the edge where we=1; the new ctrl/mask/t is visible the next cycle.
- **out.** Updated on the edge sampling rd; the CPU samples it when lock_cpu is low.
- **$2007 write latency.**
  - lock_cpu rises 1 cycle after the `we` edge.
  - vram_we occurs in the first cycle with vram_gnt=1, at the earliest 1 cycle after `we`.
  - lock_cpu falls the cycle after vram_we.
- **$2007 read latency.** Granted cycle, then RD_LAT, then lock_cpu falls. Minimum stall is 2 cycles.
- **Grant rule.** vram_gnt may be asserted in any cycle and is honoured only while vram_req=1. It may stay low indefinitely; lock_cpu stays high throughout.
- **nmi.** Rises one cycle after vblank_set when ctrl[7]=1. Rises one cycle after a ctrl write setting bit7 while vblank=1.

## Test plan

- **Address load and write.**
  - Stimulus: write $2006=$21, $2006=$08, then $2007=$5A with gnt held high.
  - Required: vram_addr=$2108, vram_we pulse with vram_out=$5A, then v=$2109.
  - Stimulus: the same sequence with ctrl=$04.
  - Required: v=$2128 after the write.
- **Buffered read.**
  - Stimulus: VRAM[$2000]=$11, VRAM[$2001]=$22; set v=$2000, then read $2007 twice.
  - Required: first read returns the reset buffer value $00, second returns $11, rd_buf=$22.
- **Stall.**
  - Stimulus: gnt low for 20 cycles after a $2007 write.
  - Required: lock_cpu high all 20 cycles; no vram_we until gnt.
  - Stimulus: reset asserted mid-wait.
  - Required: lock_cpu=0 and no write afterwards.
- **Palette.**
  - Stimulus: v=$3F10, write $2007=$2A.
  - Required: pal_we=1, pal_idx=0, pal_data=$2A, vram_req never asserts, v=$3F11.
- **Status and NMI.**
  - Stimulus: ctrl=$80, then a vblank_set pulse.
  - Required: nmi=1.
  - Stimulus: read $2002.
  - Required: returns $80; nmi=0 next cycle; w=0.
  - Stimulus: vblank_set and a $2002 read in the same cycle.
  - Required: read returns $00, vblank stays set.
- **Scroll toggle.**
  - Stimulus: write $2005=$7D, then $2005=$5E.
  - Required: fine_x=5, t[4:0]=$0F, t[9:5]=$0B, t[14:12]=6.
  - Stimulus: a $2002 read between the two writes.
  - Required: the second write is treated as the first (w reset to 0).

Source files
------------

// File: rtl/ppu_cpu_port.sv
// CPU-side PPU register file: $2000-$3FFF decode, loopy v/t/x/w scroll state,
// buffered $2007 access arbitrated onto the shared VRAM bus, vblank/NMI status.
module ppu_cpu_port #(
    parameter int INC_DEFAULT = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic [7:0]  in,
    input  logic        rd,
    input  logic        we,
    output logic [7:0]  out,
    output logic        lock_cpu,
    input  logic        vblank_set,
    input  logic        vblank_clr,
    output logic        nmi,
    output logic        vram_req,
    input  logic        vram_gnt,
    output logic [13:0] vram_addr,
    input  logic [7:0]  vram_in,
    output logic [7:0]  vram_out,
    output logic        vram_we,
    output logic        pal_we,
    output logic [4:0]  pal_idx,
    output logic [5:0]  pal_data,
    output logic [7:0]  ctrl,
    output logic [7:0]  mask,
    output logic [14:0] scroll_t,
    output logic [2:0]  fine_x
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        RD_LAT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [14:0] v;
    logic [14:0] t;
    logic        w;
    logic        vblank;
    logic [7:0]  rd_buf;
    logic [7:0]  wr_data;
    logic        sel;
    logic [2:0]  regn;
    logic        acc_rd;
    logic        acc_wr;
    logic        pal_range;
    logic [14:0] inc;
    logic [4:0]  pal_fold;
    logic        v_step;

    // Strobes are only honoured while unlocked; anything arriving during a stall is dropped.
    assign sel       = (address[15:13] == 3'b001);
    assign regn      = address[2:0];
    assign acc_rd    = rd & sel & (state == IDLE);
    assign acc_wr    = we & sel & (state == IDLE);
    assign pal_range = (v[13:8] == 6'h3F);
    assign inc       = ctrl[2] ? 15'd32 : 15'(INC_DEFAULT);
    // $10/$14/$18/$1C alias the backdrop entries $00/$04/$08/$0C.
    assign pal_fold  = {v[4] & (v[1:0] != 2'b00), v[3:0]};

    assign lock_cpu  = (state != IDLE);
    assign nmi       = vblank & ctrl[7];
    assign scroll_t  = t;
    assign vram_out  = wr_data;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        vram_req   = 1'b0;
        vram_we    = 1'b0;
        v_step     = 1'b0;
        vram_addr  = v[13:0];
        case (state)
            IDLE: begin
                if (acc_wr && regn == 3'd7 && !pal_range) begin
                    state_next = WR_WAIT;
                end else if (acc_rd && regn == 3'd7) begin
                    state_next = RD_WAIT;
                end
            end
            WR_WAIT: begin
                vram_req = 1'b1;
                if (vram_gnt) begin
                    vram_we    = 1'b1;
                    v_step     = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_WAIT: begin
                vram_req = 1'b1;
                // Palette reads refill the buffer from the nametable underneath.
                if (pal_range) begin
                    vram_addr = v[13:0] & 14'h2FFF;
                end
                if (vram_gnt) begin
                    state_next = RD_LAT;
                end
            end
            RD_LAT: begin
                v_step     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ctrl     <= 8'h00;
            mask     <= 8'h00;
            t        <= 15'h0000;
            v        <= 15'h0000;
            fine_x   <= 3'd0;
            w        <= 1'b0;
            vblank   <= 1'b0;
            rd_buf   <= 8'h00;
            wr_data  <= 8'h00;
            out      <= 8'h00;
            pal_we   <= 1'b0;
            pal_idx  <= 5'd0;
            pal_data <= 6'd0;
        end else begin
            pal_we <= 1'b0;

            if (vblank_set) begin
                vblank <= 1'b1;
            end else if (vblank_clr || (acc_rd && regn == 3'd2)) begin
                vblank <= 1'b0;
            end

            if (v_step) begin
                v <= v + inc;
            end
            if (state == RD_LAT) begin
                rd_buf <= vram_in;
            end

            if (acc_wr) begin
                case (regn)
                    3'd0: begin
                        ctrl      <= in;
                        t[11:10]  <= in[1:0];
                    end
                    3'd1: mask <= in;
                    3'd5: begin
                        if (!w) begin
                            t[4:0] <= in[7:3];
                            fine_x <= in[2:0];
                            w      <= 1'b1;
                        end else begin
                            t[14:12] <= in[2:0];
                            t[9:5]   <= in[7:3];
                            w        <= 1'b0;
                        end
                    end
                    3'd6: begin
                        if (!w) begin
                            t[13:8] <= in[5:0];
                            t[14]   <= 1'b0;
                            w       <= 1'b1;
                        end else begin
                            t[7:0] <= in;
                            v      <= {t[14:8], in};
                            w      <= 1'b0;
                        end
                    end
                    3'd7: begin
                        if (pal_range) begin
                            pal_we   <= 1'b1;
                            pal_idx  <= pal_fold;
                            pal_data <= in[5:0];
                            v        <= v + inc;
                        end else begin
                            wr_data <= in;
                        end
                    end
                    default: ;
                endcase
            end

            if (acc_rd) begin
                case (regn)
                    3'd2: begin
                        // A read racing the vblank edge reports clear but keeps the flag.
                        out <= {vblank & ~vblank_set, 7'b0};
                        w   <= 1'b0;
                    end
                    3'd7:    out <= rd_buf;
                    default: out <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_cpu_port.sv
// Directed bench for ppu_cpu_port with a small VRAM model answering bus grants.
module tb_ppu_cpu_port;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  cpu_in = 8'h00;
    logic        rd = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  cpu_out;
    logic        lock_cpu;
    logic        vblank_set = 1'b0;
    logic        vblank_clr = 1'b0;
    logic        nmi;
    logic        vram_req;
    logic        vram_gnt = 1'b1;
    logic [13:0] vram_addr;
    logic [7:0]  vram_in = 8'h00;
    logic [7:0]  vram_out;
    logic        vram_we;
    logic        pal_we;
    logic [4:0]  pal_idx;
    logic [5:0]  pal_data;
    logic [7:0]  ctrl;
    logic [7:0]  mask;
    logic [14:0] scroll_t;
    logic [2:0]  fine_x;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    logic [7:0] mem [0:16383];

    ppu_cpu_port #(.INC_DEFAULT(1)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .in(cpu_in),
        .rd(rd), .we(we), .out(cpu_out), .lock_cpu(lock_cpu),
        .vblank_set(vblank_set), .vblank_clr(vblank_clr), .nmi(nmi),
        .vram_req(vram_req), .vram_gnt(vram_gnt), .vram_addr(vram_addr),
        .vram_in(vram_in), .vram_out(vram_out), .vram_we(vram_we),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .ctrl(ctrl), .mask(mask), .scroll_t(scroll_t), .fine_x(fine_x)
    );

    always #5 clock = ~clock;

    // VRAM: writes land on the granted edge, read data appears the cycle after the grant.
    always @(posedge clock) begin
        if (vram_req && vram_gnt) begin
            if (vram_we) begin
                mem[vram_addr] = vram_out;
                wr_count = wr_count + 1;
            end else begin
                vram_in = mem[vram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        address = a;
        cpu_in  = d;
        we      = 1'b1;
        @(negedge clock);
        we      = 1'b0;
        address = 16'h0000;
    endtask

    task automatic bus_rd(input logic [15:0] a);
        @(negedge clock);
        address = a;
        rd      = 1'b1;
        @(negedge clock);
        rd      = 1'b0;
        address = 16'h0000;
    endtask

    task automatic wr(input logic [2:0] r, input logic [7:0] d);
        bus_wr(16'h2000 + {13'd0, r}, d);
    endtask

    task automatic rdr(input logic [2:0] r);
        bus_rd(16'h2000 + {13'd0, r});
    endtask

    task automatic wait_unlock(output int cyc);
        cyc = 0;
        while (lock_cpu && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        if (lock_cpu) chk("unlock_timeout", 32'(lock_cpu), 32'd0);
    endtask

    task automatic pulse_set();
        @(negedge clock);
        vblank_set = 1'b1;
        @(negedge clock);
        vblank_set = 1'b0;
    endtask

    initial begin
        int cyc;
        int n_lock;
        int n_we;
        int wc0;

        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h2000] = 8'h11;
        mem[14'h2001] = 8'h22;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        chk("rst_out", 32'(cpu_out), 32'h00);
        chk("rst_lock", 32'(lock_cpu), 32'd0);
        chk("rst_nmi", 32'(nmi), 32'd0);
        chk("rst_req", 32'(vram_req), 32'd0);
        chk("rst_vwe", 32'(vram_we), 32'd0);
        chk("rst_palwe", 32'(pal_we), 32'd0);
        chk("rst_vaddr", 32'(vram_addr), 32'h0000);
        chk("rst_ctrl", 32'(ctrl), 32'h00);
        chk("rst_mask", 32'(mask), 32'h00);
        chk("rst_t", 32'(scroll_t), 32'h0000);
        chk("rst_finex", 32'(fine_x), 32'd0);

        // Address load and write, +1 increment
        wr(3'd6, 8'h21);
        wr(3'd6, 8'h08);
        chk("v_load", 32'(vram_addr), 32'h2108);
        wr(3'd7, 8'h5A);
        chk("wr_lock", 32'(lock_cpu), 32'd1);
        chk("wr_vwe", 32'(vram_we), 32'd1);
        chk("wr_addr", 32'(vram_addr), 32'h2108);
        chk("wr_data", 32'(vram_out), 32'h5A);
        @(negedge clock);
        chk("wr_unlock", 32'(lock_cpu), 32'd0);
        chk("wr_vinc1", 32'(vram_addr), 32'h2109);
        chk("wr_mem", 32'(mem[14'h2108]), 32'h5A);

        // Same with +32 increment
        wr(3'd0, 8'h04);
        chk("ctrl04", 32'(ctrl), 32'h04);
        wr(3'd6, 8'h21);
        wr(3'd6, 8'h08);
        wr(3'd7, 8'h5A);
        wait_unlock(cyc);
        chk("wr_vinc32", 32'(vram_addr), 32'h2128);

        // Buffered read
        wr(3'd0, 8'h00);
        wr(3'd6, 8'h20);
        wr(3'd6, 8'h00);
        rdr(3'd7);
        chk("rd1_out", 32'(cpu_out), 32'h00);
        chk("rd1_lock", 32'(lock_cpu), 32'd1);
        wait_unlock(cyc);
        chk("rd1_stall", 32'(cyc), 32'd2);
        rdr(3'd7);
        wait_unlock(cyc);
        chk("rd2_out", 32'(cpu_out), 32'h11);
        rdr(3'd7);
        wait_unlock(cyc);
        chk("rd3_buf22", 32'(cpu_out), 32'h22);
        chk("rd_vaddr", 32'(vram_addr), 32'h2003);

        // Stall with grant withheld for 20 cycles
        vram_gnt = 1'b0;
        wc0 = wr_count;
        wr(3'd7, 8'h77);
        n_lock = 0;
        n_we = 0;
        for (int i = 0; i < 20; i++) begin
            if (lock_cpu) n_lock++;
            if (vram_we) n_we++;
            @(negedge clock);
        end
        chk("stall_lock20", 32'(n_lock), 32'd20);
        chk("stall_no_we", 32'(n_we), 32'd0);
        chk("stall_no_wr", 32'(wr_count - wc0), 32'd0);
        vram_gnt = 1'b1;
        #1;
        chk("stall_gnt_we", 32'(vram_we), 32'd1);
        @(negedge clock);
        chk("stall_unlock", 32'(lock_cpu), 32'd0);
        chk("stall_mem", 32'(mem[14'h2003]), 32'h77);

        // Reset while waiting for a slot
        vram_gnt = 1'b0;
        wc0 = wr_count;
        wr(3'd7, 8'h99);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("rstw_lock", 32'(lock_cpu), 32'd0);
        chk("rstw_req", 32'(vram_req), 32'd0);
        chk("rstw_out", 32'(cpu_out), 32'h00);
        chk("rstw_vaddr", 32'(vram_addr), 32'h0000);
        vram_gnt = 1'b1;
        repeat (5) @(negedge clock);
        chk("rstw_no_wr", 32'(wr_count - wc0), 32'd0);
        chk("rstw_mem", 32'(mem[14'h2004]), 32'h00);

        // Palette writes bypass the VRAM bus
        wr(3'd6, 8'h3F);
        wr(3'd6, 8'h10);
        wc0 = wr_count;
        wr(3'd7, 8'h2A);
        chk("pal_we", 32'(pal_we), 32'd1);
        chk("pal_idx_fold", 32'(pal_idx), 32'h00);
        chk("pal_data", 32'(pal_data), 32'h2A);
        chk("pal_req", 32'(vram_req), 32'd0);
        chk("pal_lock", 32'(lock_cpu), 32'd0);
        chk("pal_vinc", 32'(vram_addr), 32'h3F11);
        @(negedge clock);
        chk("pal_we_1cyc", 32'(pal_we), 32'd0);
        chk("pal_req2", 32'(vram_req), 32'd0);
        wr(3'd7, 8'hFF);
        chk("pal_idx_11", 32'(pal_idx), 32'h11);
        chk("pal_data_6b", 32'(pal_data), 32'h3F);
        chk("pal_no_wr", 32'(wr_count - wc0), 32'd0);

        // Palette-range read refills from the mirrored nametable address
        vram_gnt = 1'b0;
        rdr(3'd7);
        chk("palrd_req", 32'(vram_req), 32'd1);
        chk("palrd_addr", 32'(vram_addr), 32'h2F12);
        vram_gnt = 1'b1;
        wait_unlock(cyc);
        chk("palrd_vinc", 32'(vram_addr), 32'h3F13);

        // Status and NMI
        wr(3'd0, 8'h80);
        chk("nmi_pre", 32'(nmi), 32'd0);
        pulse_set();
        chk("nmi_set", 32'(nmi), 32'd1);
        rdr(3'd2);
        chk("stat_80", 32'(cpu_out), 32'h80);
        chk("nmi_clr_rd", 32'(nmi), 32'd0);
        @(negedge clock);
        vblank_set = 1'b1;
        address = 16'h2002;
        rd = 1'b1;
        @(negedge clock);
        vblank_set = 1'b0;
        rd = 1'b0;
        address = 16'h0000;
        chk("race_out", 32'(cpu_out), 32'h00);
        chk("race_nmi", 32'(nmi), 32'd1);
        bus_rd(16'h5002);
        chk("oor_rd_hold", 32'(cpu_out), 32'h00);
        chk("oor_rd_nmi", 32'(nmi), 32'd1);
        rdr(3'd2);
        chk("race_kept", 32'(cpu_out), 32'h80);
        rdr(3'd4);
        chk("oam_rd0", 32'(cpu_out), 32'h00);

        pulse_set();
        @(negedge clock);
        vblank_clr = 1'b1;
        @(negedge clock);
        vblank_clr = 1'b0;
        chk("vclr_nmi", 32'(nmi), 32'd0);
        @(negedge clock);
        vblank_clr = 1'b1;
        vblank_set = 1'b1;
        @(negedge clock);
        vblank_clr = 1'b0;
        vblank_set = 1'b0;
        chk("set_wins", 32'(nmi), 32'd1);
        wr(3'd0, 8'h00);
        chk("nmi_ctrl_off", 32'(nmi), 32'd0);
        wr(3'd0, 8'h80);
        chk("nmi_ctrl_on", 32'(nmi), 32'd1);
        rdr(3'd2);

        // Decode: mirrors accepted, out-of-range ignored
        bus_wr(16'h3FF9, 8'h1E);
        chk("mirror_mask", 32'(mask), 32'h1E);
        bus_wr(16'h4001, 8'hFF);
        bus_wr(16'h1001, 8'hFF);
        chk("oor_mask", 32'(mask), 32'h1E);
        wr(3'd3, 8'hAA);
        wr(3'd4, 8'hAA);
        chk("oam_wr_ign", 32'(mask), 32'h1E);

        // Scroll toggle
        wr(3'd0, 8'h00);
        wr(3'd5, 8'h7D);
        wr(3'd5, 8'h5E);
        chk("sc_finex", 32'(fine_x), 32'd5);
        chk("sc_t40", 32'(scroll_t[4:0]), 32'h0F);
        chk("sc_t95", 32'(scroll_t[9:5]), 32'h0B);
        chk("sc_t1412", 32'(scroll_t[14:12]), 32'd6);
        wr(3'd5, 8'h7D);
        rdr(3'd2);
        wr(3'd5, 8'h5E);
        chk("sc_w_finex", 32'(fine_x), 32'd6);
        chk("sc_w_t40", 32'(scroll_t[4:0]), 32'h0B);
        wr(3'd5, 8'h00);
        chk("sc_w_second", 32'(scroll_t[14:12]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
